// File: rtl/serial_slave_mem.sv
// Bit-serial memory slave: deserialises address/burst/write-data streams into a local RAM and
// serialises RAM words back out on reads, one bit per accepted cycle, MSB first.
module serial_slave_mem #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic read_en,
  input  logic write_en,
  input  logic master_valid,
  input  logic master_ready,
  input  logic rx_done_in,
  input  logic rx_address,
  input  logic rx_burst,
  input  logic rx_data,
  output logic slave_ready,
  output logic slave_valid,
  output logic tx_data
);

  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int ACNT_W = $clog2(ADDR_WIDTH + 1);
  localparam int WORDS  = 2 ** ADDR_WIDTH;
  localparam logic [BURST_WIDTH:0] LAST_WORD = 1;

  typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, RD_FETCH, RD_SEND, RD_WAIT} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  mem [WORDS];
  logic [ADDR_WIDTH-1:0]  addr;
  logic [BURST_WIDTH-1:0] burst_sr;
  logic [BURST_WIDTH:0]   words_left;
  logic [ACNT_W-1:0]      addr_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  data_sr;
  logic                   is_read;

  logic                   addr_last;
  logic                   word_last;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [BURST_WIDTH-1:0] burst_next;
  logic [DATA_WIDTH-1:0]  wr_word;
  logic [DATA_WIDTH-1:0]  rd_shift;

  always_comb begin
    addr_last  = (addr_cnt == ACNT_W'(ADDR_WIDTH - 1));
    word_last  = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    addr_next  = (addr << 1) | ADDR_WIDTH'(rx_address);
    burst_next = burst_sr;
    if (addr_cnt < ACNT_W'(BURST_WIDTH))
      burst_next = (burst_sr << 1) | BURST_WIDTH'(rx_burst);
    wr_word    = (data_sr << 1) | DATA_WIDTH'(rx_data);
    rd_shift   = data_sr << 1;
    // The completing bit commits the word even if rx_done_in arrives on the same cycle.
    mem_we     = !reset && (state == WR_DATA) && master_valid && word_last;
  end

  // NOTE: the RAM array has no reset branch; clearing it would prevent block-RAM mapping
  // and its contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[addr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      burst_sr    <= '0;
      words_left  <= '0;
      addr_cnt    <= '0;
      bit_cnt     <= '0;
      data_sr     <= '0;
      is_read     <= 1'b0;
      slave_ready <= 1'b0;
      slave_valid <= 1'b0;
      tx_data     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          slave_ready <= 1'b1;
          slave_valid <= 1'b0;
          tx_data     <= 1'b0;
          if (master_valid && (read_en ^ write_en)) begin
            state    <= ADDR;
            is_read  <= read_en;
            addr     <= ADDR_WIDTH'(rx_address);
            burst_sr <= BURST_WIDTH'(rx_burst);
            addr_cnt <= ACNT_W'(1);
            bit_cnt  <= '0;
          end
        end

        ADDR: begin
          if (rx_done_in) begin
            state <= IDLE;
          end else if (master_valid) begin
            addr     <= addr_next;
            burst_sr <= burst_next;
            addr_cnt <= addr_cnt + 1'b1;
            if (addr_last) begin
              words_left <= {1'b0, burst_next} + 1'b1;
              bit_cnt    <= '0;
              if (is_read) begin
                state       <= RD_FETCH;
                slave_ready <= 1'b0;
              end else begin
                state <= WR_DATA;
              end
            end
          end
        end

        WR_DATA: begin
          if (master_valid) begin
            data_sr <= wr_word;
            bit_cnt <= bit_cnt + 1'b1;
            if (word_last) begin
              bit_cnt    <= '0;
              addr       <= addr + 1'b1;
              words_left <= words_left - 1'b1;
            end
          end
          if (rx_done_in || (master_valid && word_last && words_left == LAST_WORD))
            state <= IDLE;
        end

        RD_FETCH: begin
          if (rx_done_in) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
          end else begin
            data_sr     <= mem[addr];
            tx_data     <= mem[addr][DATA_WIDTH-1];
            slave_valid <= 1'b1;
            bit_cnt     <= '0;
            state       <= RD_SEND;
          end
        end

        RD_SEND: begin
          if (rx_done_in) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
            slave_valid <= 1'b0;
            tx_data     <= 1'b0;
          end else if (master_ready) begin
            if (word_last) begin
              addr        <= addr + 1'b1;
              bit_cnt     <= '0;
              slave_valid <= 1'b0;
              tx_data     <= 1'b0;
              if (words_left == LAST_WORD) begin
                state <= RD_WAIT;
              end else begin
                words_left <= words_left - 1'b1;
                state      <= RD_FETCH;
              end
            end else begin
              data_sr <= rd_shift;
              tx_data <= rd_shift[DATA_WIDTH-1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        RD_WAIT: begin
          tx_data <= 1'b0;
          if (rx_done_in) begin
            state       <= IDLE;
            slave_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_mem.sv
// Scoreboard bench for serial_slave_mem: a bench-side RAM model predicts every read bit, which
// is queued when the read is issued and compared as the slave serialises it.
module tb_serial_slave_mem;

  logic clk = 1'b0;
  logic reset, read_en, write_en, master_valid, master_ready, rx_done_in;
  logic rx_address, rx_burst, rx_data;
  logic slave_ready, slave_valid, tx_data;

  logic [7:0] model_mem [4096];
  logic [7:0] wdata [16];
  logic       exp_q [$];
  int         vectors = 0;
  int         errors  = 0;

  serial_slave_mem #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .BURST_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
    .master_valid(master_valid), .master_ready(master_ready), .rx_done_in(rx_done_in),
    .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_header(input bit rd, input logic [11:0] a, input logic [3:0] b,
                             input bit stall);
    read_en  = rd;
    write_en = !rd;
    for (int i = 0; i < 12; i++) begin
      if (stall && i[0]) begin
        master_valid = 1'b0;
        rx_address   = ~a[11-i];
        rx_burst     = 1'b1;
        tick();
      end
      master_valid = 1'b1;
      rx_address   = a[11-i];
      rx_burst     = (i < 4) ? b[3-i] : 1'b0;
      tick();
    end
    master_valid = 1'b0;
  endtask

  // Sends nbits data bits from wdata; fewer than a full burst aborts with rx_done_in unless
  // done_last raises rx_done_in together with the final bit.
  task automatic do_write(input logic [11:0] a, input logic [3:0] b, input int nbits,
                          input bit stall, input bit done_last);
    send_header(1'b0, a, b, stall);
    for (int i = 0; i < nbits; i++) begin
      if (stall && i[0]) begin
        master_valid = 1'b0;
        rx_data      = ~wdata[i/8][7-(i%8)];
        tick();
      end
      master_valid = 1'b1;
      rx_data      = wdata[i/8][7-(i%8)];
      rx_done_in   = done_last && (i == nbits - 1);
      tick();
    end
    master_valid = 1'b0;
    rx_done_in   = 1'b0;
    for (int w = 0; w < nbits / 8; w++) model_mem[a + 12'(w)] = wdata[w];
    if (nbits < (int'(b) + 1) * 8 && !done_last) begin
      rx_done_in = 1'b1;
      tick();
      rx_done_in = 1'b0;
    end
    write_en = 1'b0;
    check("wr_end_ready", slave_ready, 1);
    check("wr_end_valid", slave_valid, 0);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [3:0] b, input int stall_bit);
    int  nbits    = (int'(b) + 1) * 8;
    int  got      = 0;
    int  cyc      = 0;
    int  idle_run = 0;
    bit  stalled  = 1'b0;
    for (int w = 0; w <= int'(b); w++)
      for (int k = 7; k >= 0; k--) exp_q.push_back(model_mem[a + 12'(w)][k]);
    send_header(1'b1, a, b, 1'b0);
    master_ready = 1'b1;
    while (got < nbits && cyc < 400) begin
      cyc++;
      check("rd_ready_low", slave_ready, 0);
      if (!slave_valid) begin
        check("tx_idle_zero", tx_data, 0);
        idle_run++;
      end else begin
        if (got > 0 && got % 8 == 0) check("word_gap", idle_run, 1);
        idle_run = 0;
        if (got == stall_bit && !stalled) begin
          stalled      = 1'b1;
          master_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            tick();
            check("stall_valid", slave_valid, 1);
            check("stall_tx", tx_data, exp_q[0]);
          end
          master_ready = 1'b1;
        end
        check("rd_bit", tx_data, exp_q.pop_front());
        got++;
      end
      tick();
    end
    check("rd_bits_seen", got, nbits);
    for (int s = 0; s < 2; s++) begin
      check("rd_wait_valid", slave_valid, 0);
      check("rd_wait_tx", tx_data, 0);
      check("rd_wait_ready", slave_ready, 0);
      tick();
    end
    rx_done_in = 1'b1;
    tick();
    rx_done_in   = 1'b0;
    read_en      = 1'b0;
    master_ready = 1'b0;
    check("rd_done_ready", slave_ready, 1);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    reset = 1'b1; read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
    master_ready = 1'b0; rx_done_in = 1'b0;
    rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
    tick(); tick();
    check("rst_ready", slave_ready, 0);
    check("rst_valid", slave_valid, 0);
    check("rst_tx", tx_data, 0);
    reset = 1'b0;
    tick();
    check("idle_ready", slave_ready, 1);

    // Single write then read
    wdata[0] = 8'hA5;
    do_write(12'h005, 4'd0, 8, 1'b0, 1'b0);
    do_read(12'h005, 4'd0, -1);

    // Reset held for 3 cycles while bits are being sent
    send_header(1'b1, 12'h005, 4'd0, 1'b0);
    master_ready = 1'b1;
    cyc = 0;
    while (!slave_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rst_reach_send", slave_valid, 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midrst_ready", slave_ready, 0);
    check("midrst_valid", slave_valid, 0);
    check("midrst_tx", tx_data, 0);
    tick(); tick();
    reset = 1'b0; read_en = 1'b0; master_ready = 1'b0;
    tick();
    check("post_rst_ready", slave_ready, 1);
    check("post_rst_valid", slave_valid, 0);
    do_read(12'h005, 4'd0, -1);

    // Burst wrapping past the top address
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
    do_write(12'hFFF, 4'd2, 24, 1'b0, 1'b0);
    do_read(12'hFFF, 4'd2, -1);
    do_read(12'h001, 4'd0, -1);

    // Stalls on both directions
    wdata[0] = 8'h5C; wdata[1] = 8'hE3;
    do_write(12'h0A0, 4'd1, 16, 1'b1, 1'b0);
    do_read(12'h0A0, 4'd1, 3);
    do_read(12'h0A1, 4'd0, 12);

    // Abort mid-word: pre-fill, then abort 4 bits into word 2
    wdata[0] = 8'hF0; wdata[1] = 8'hF1; wdata[2] = 8'hF2; wdata[3] = 8'hF3;
    do_write(12'h200, 4'd3, 32, 1'b0, 1'b0);
    wdata[0] = 8'h12; wdata[1] = 8'h34;
    do_write(12'h200, 4'd3, 12, 1'b0, 1'b0);
    do_read(12'h200, 4'd3, -1);

    // rx_done_in on the last bit of a word: word kept, next transaction starts cleanly
    wdata[0] = 8'h77;
    do_write(12'h300, 4'd3, 8, 1'b0, 1'b1);
    wdata[0] = 8'h99;
    do_write(12'h301, 4'd0, 8, 1'b0, 1'b0);
    do_read(12'h300, 4'd1, -1);

    // Both enables high: request ignored, RAM untouched
    read_en = 1'b1; write_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      master_valid = 1'b1;
      rx_address   = (i < 12) ? (12'h005 >> (11 - i)) & 12'h001 : 12'h000;
      rx_burst     = 1'b0;
      rx_data      = 1'b0;
      tick();
      check("illegal_ready", slave_ready, 1);
      check("illegal_valid", slave_valid, 0);
    end
    master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;
    tick();
    do_read(12'h005, 4'd0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
